seq_int_divider_16: RTL



---
 rtl/seq_int_divider_16_if.sv | 25 ++
 rtl/seq_int_divider_16.sv | 66 ++++++
 2 files changed

// File: rtl/seq_int_divider_16_if.sv
// seq_int_divider_16_if: operand and result stream channels of the sequential divider
interface seq_int_divider_16_if #(parameter int WIDTH = 16);
  logic               s_axis_dividend_tvalid;
  logic               s_axis_dividend_tready;
  logic [WIDTH-1:0]   s_axis_dividend_tdata;
  logic               s_axis_divisor_tvalid;
  logic               s_axis_divisor_tready;
  logic [WIDTH-1:0]   s_axis_divisor_tdata;
  logic               m_axis_dout_tvalid;
  logic               m_axis_dout_tready;
  logic [2*WIDTH-1:0] m_axis_dout_tdata;
  logic               m_axis_dout_tuser;
  modport master (
    output s_axis_dividend_tvalid, s_axis_dividend_tdata,
    output s_axis_divisor_tvalid, s_axis_divisor_tdata, m_axis_dout_tready,
    input  s_axis_dividend_tready, s_axis_divisor_tready,
    input  m_axis_dout_tvalid, m_axis_dout_tdata, m_axis_dout_tuser
  );
  modport slave (
    input  s_axis_dividend_tvalid, s_axis_dividend_tdata,
    input  s_axis_divisor_tvalid, s_axis_divisor_tdata, m_axis_dout_tready,
    output s_axis_dividend_tready, s_axis_divisor_tready,
    output m_axis_dout_tvalid, m_axis_dout_tdata, m_axis_dout_tuser
  );
endinterface

// File: rtl/seq_int_divider_16.sv
// seq_int_divider_16: radix-2 restoring unsigned divider, one quotient bit per clock
module seq_int_divider_16 #(parameter int WIDTH = 16) (
  input logic clk,
  input logic rst,
  seq_int_divider_16_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] q, r, d;
  logic [WIDTH:0] r_sh;
  logic [CW-1:0] cnt;
  logic ready, valid, dz, ge;
  // remainder never exceeds the divisor, so only the shifted value needs the extra bit
  assign r_sh = {r, q[WIDTH-1]};
  assign ge = r_sh >= {1'b0, d};
  assign bus.s_axis_dividend_tready = ready;
  assign bus.s_axis_divisor_tready = ready;
  assign bus.m_axis_dout_tvalid = valid;
  assign bus.m_axis_dout_tdata = {q, r};
  assign bus.m_axis_dout_tuser = dz;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ready <= 1'b0;
      valid <= 1'b0;
      q <= '0;
      r <= '0;
      d <= '0;
      cnt <= '0;
      dz <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ready <= 1'b1;
          if (ready && bus.s_axis_dividend_tvalid && bus.s_axis_divisor_tvalid) begin
            state <= CALC;
            ready <= 1'b0;
            q <= bus.s_axis_dividend_tdata;
            r <= '0;
            d <= bus.s_axis_divisor_tdata;
            dz <= bus.s_axis_divisor_tdata == '0;
            cnt <= '0;
          end
        end
        CALC: begin
          q <= {q[WIDTH-2:0], ge};
          r <= ge ? r_sh[WIDTH-1:0] - d : r_sh[WIDTH-1:0];
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state <= DONE;
            valid <= 1'b1;
          end
        end
        DONE: begin
          if (bus.m_axis_dout_tready) begin
            state <= IDLE;
            valid <= 1'b0;
            ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
